// File: rtl/biquad_cascade.sv
// biquad_cascade
//   NUM_STAGES Direct Form I biquads in series. One signed multiplier-accumulator
//   is shared by all stages: 5 MAC cycles plus 1 write-back cycle per stage.
//   Coefficients are written into a shadow bank and copied to the active bank
//   when a sample is accepted. Each stage can be bypassed per sample.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     sample handshake, in_sample = x[n]
//   coef_we/coef_stage/coef_idx/coef_wdata
//                         shadow coefficient write (idx 0..4 = b0,b1,b2,a1,a2)
//   bypass                per-stage bypass, captured with the sample
//   sat_clr               clears sat_flag
//   out_valid/out_sample  one-cycle result pulse, sample held until next result
//   sat_flag              sticky saturation indicator
//   busy                  inverse of in_ready
module biquad_cascade #(
  parameter  int DATA_W     = 16,
  parameter  int COEF_W     = 16,
  parameter  int FRAC_BITS  = 14,
  parameter  int NUM_STAGES = 3,
  parameter  int ACC_W      = 40,
  localparam int SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic                     coef_we,
  input  logic [SW-1:0]            coef_stage,
  input  logic [2:0]               coef_idx,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic [NUM_STAGES-1:0]    bypass,
  input  logic                     sat_clr,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_sample,
  output logic                     sat_flag,
  output logic                     busy
);

  localparam int PW = DATA_W + COEF_W;

  localparam logic signed [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic signed [ACC_W-1:0]  ROUND    = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS-1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  SAT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] D_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

  state_t                     state;
  logic [SW-1:0]              stage;
  logic [2:0]                 term;
  logic [NUM_STAGES-1:0]      byp;
  logic signed [DATA_W-1:0]   cur_x;
  logic signed [ACC_W-1:0]    acc;

  logic signed [COEF_W-1:0]   shadow [NUM_STAGES][5];
  logic signed [COEF_W-1:0]   active [NUM_STAGES][5];
  logic signed [DATA_W-1:0]   x1 [NUM_STAGES];
  logic signed [DATA_W-1:0]   x2 [NUM_STAGES];
  logic signed [DATA_W-1:0]   y1 [NUM_STAGES];
  logic signed [DATA_W-1:0]   y2 [NUM_STAGES];

  logic                       transfer;
  logic                       last_stage;
  logic                       coef_ok;
  logic signed [COEF_W-1:0]   mac_coef;
  logic signed [DATA_W-1:0]   mac_data;
  logic signed [PW-1:0]       coef_ext;
  logic signed [PW-1:0]       data_ext;
  logic signed [PW-1:0]       prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    rounded;
  logic                       clamp_hi;
  logic                       clamp_lo;
  logic signed [DATA_W-1:0]   stage_out;
  logic                       stage_sat;

  assign transfer   = in_valid && in_ready;
  assign last_stage = (stage == SW'(NUM_STAGES - 1));
  assign coef_ok    = coef_we && (coef_idx <= 3'd4) && (int'(coef_stage) < NUM_STAGES);
  assign busy       = ~in_ready;

  // Operand selection for the shared MAC; a1/a2 terms are subtracted.
  always_comb begin
    mac_coef = active[stage][term];
    mac_data = cur_x;
    case (term)
      3'd1:    mac_data = x1[stage];
      3'd2:    mac_data = x2[stage];
      3'd3:    mac_data = y1[stage];
      3'd4:    mac_data = y2[stage];
      default: mac_data = cur_x;
    endcase
    // Operands are widened to the full product width so the low PW bits of the
    // product hold the exact signed result.
    coef_ext = {{DATA_W{mac_coef[COEF_W-1]}}, mac_coef};
    data_ext = {{COEF_W{mac_data[DATA_W-1]}}, mac_data};
    prod     = coef_ext * data_ext;
    prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    if (term == 3'd0)
      acc_next = prod_ext;
    else if (term >= 3'd3)
      acc_next = acc - prod_ext;
    else
      acc_next = acc + prod_ext;
  end

  // Round-half-up, clamp to the sample range; a bypassed stage passes its input.
  always_comb begin
    rounded  = (acc + ROUND) >>> FRAC_BITS;
    clamp_hi = (rounded > SAT_MAX);
    clamp_lo = (rounded < SAT_MIN);
    if (byp[stage])
      stage_out = cur_x;
    else if (clamp_hi)
      stage_out = D_MAX;
    else if (clamp_lo)
      stage_out = D_MIN;
    else
      stage_out = rounded[DATA_W-1:0];
    stage_sat = (state == WB) && !byp[stage] && (clamp_hi || clamp_lo);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      stage      <= '0;
      term       <= '0;
      byp        <= '0;
      cur_x      <= '0;
      acc        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_sample <= '0;
      sat_flag   <= 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
        for (int i = 0; i < 5; i++) begin
          shadow[s][i] <= (i == 0) ? COEF_ONE : '0;
          active[s][i] <= (i == 0) ? COEF_ONE : '0;
        end
      end
    end else begin
      out_valid <= 1'b0;

      // Set has priority over clear when both happen on one edge.
      if (sat_clr)
        sat_flag <= 1'b0;
      if (stage_sat)
        sat_flag <= 1'b1;

      // Active takes the pre-edge shadow, so a same-edge write waits a sample.
      if (transfer) begin
        for (int s = 0; s < NUM_STAGES; s++)
          for (int i = 0; i < 5; i++)
            active[s][i] <= shadow[s][i];
      end
      if (coef_ok)
        shadow[coef_stage][coef_idx] <= coef_wdata;

      case (state)
        IDLE: begin
          if (transfer) begin
            cur_x    <= in_sample;
            byp      <= bypass;
            stage    <= '0;
            term     <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (term == 3'd4) begin
            term  <= '0;
            state <= WB;
          end else begin
            term <= term + 3'd1;
          end
        end
        WB: begin
          if (!byp[stage]) begin
            x2[stage] <= x1[stage];
            x1[stage] <= cur_x;
            y2[stage] <= y1[stage];
            y1[stage] <= stage_out;
          end
          cur_x <= stage_out;
          if (last_stage) begin
            out_sample <= stage_out;
            out_valid  <= 1'b1;
            in_ready   <= 1'b1;
            state      <= IDLE;
          end else begin
            stage <= stage + 1'b1;
            state <= MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_cascade.sv
// tb_biquad_cascade
//   Self-checking bench for biquad_cascade (NUM_STAGES=3, Q2.14 coefficients).
//   A behavioural integer model of the cascade produces each expected sample
//   when the sample is driven; the result is queued and popped when the DUT
//   raises out_valid.
module tb_biquad_cascade;

  localparam int NS      = 3;
  localparam int LATENCY = 6 * NS;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_sample;
  logic               coef_we;
  logic [1:0]         coef_stage;
  logic [2:0]         coef_idx;
  logic signed [15:0] coef_wdata;
  logic [NS-1:0]      bypass;
  logic               sat_clr;
  logic               out_valid;
  logic signed [15:0] out_sample;
  logic               sat_flag;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  // Behavioural model state
  int m_sh [NS][5];
  int m_ac [NS][5];
  int m_x1 [NS];
  int m_x2 [NS];
  int m_y1 [NS];
  int m_y2 [NS];
  bit m_sat;

  biquad_cascade #(
    .DATA_W(16), .COEF_W(16), .FRAC_BITS(14), .NUM_STAGES(NS), .ACC_W(40)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .coef_we(coef_we), .coef_stage(coef_stage), .coef_idx(coef_idx),
    .coef_wdata(coef_wdata), .bypass(bypass), .sat_clr(sat_clr),
    .out_valid(out_valid), .out_sample(out_sample),
    .sat_flag(sat_flag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < 5; i++) begin
        m_sh[s][i] = (i == 0) ? 16384 : 0;
        m_ac[s][i] = (i == 0) ? 16384 : 0;
      end
      m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
    end
    m_sat = 1'b0;
    exp_q.delete();
  endtask

  // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, rounded half-up then clamped.
  task automatic model_run(input int xin, input logic [NS-1:0] byp, output int yout);
    longint acc;
    longint r;
    int     x;
    x = xin;
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 5; i++)
        m_ac[s][i] = m_sh[s][i];
    for (int s = 0; s < NS; s++) begin
      if (!byp[s]) begin
        acc = longint'(m_ac[s][0]) * x + longint'(m_ac[s][1]) * m_x1[s]
            + longint'(m_ac[s][2]) * m_x2[s] - longint'(m_ac[s][3]) * m_y1[s]
            - longint'(m_ac[s][4]) * m_y2[s];
        r = (acc + 64'sd8192) >>> 14;
        if (r > 32767) begin r = 32767; m_sat = 1'b1; end
        else if (r < -32768) begin r = -32768; m_sat = 1'b1; end
        m_x2[s] = m_x1[s]; m_x1[s] = x;
        m_y2[s] = m_y1[s]; m_y1[s] = int'(r);
        x = int'(r);
      end
    end
    yout = x;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sample = '0; coef_we = 1'b0; coef_stage = '0;
    coef_idx = '0; coef_wdata = '0; bypass = '0; sat_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int stage, input int idx, input int val);
    coef_stage = 2'(stage); coef_idx = 3'(idx); coef_wdata = 16'(val);
    coef_we = 1'b1;
    @(posedge clk);
    #1 coef_we = 1'b0;
    if (idx <= 4 && stage < NS) m_sh[stage][idx] = val;
  endtask

  // Drives one sample; returns 1ns after the transfer edge.
  task automatic send(input int x, input logic [NS-1:0] byp);
    int cnt;
    int y;
    cnt = 0;
    while (!in_ready && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL send_wait: in_ready=%0b after %0d cycles, required 1", in_ready, cnt);
      return;
    end
    in_sample = 16'(x); bypass = byp; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_run(x, byp, y);
    exp_q.push_back(y);
  endtask

  // Waits (bounded) for out_valid; cyc counts edges since the call.
  task automatic collect(output int y, output int cyc, output bit to);
    cyc = 0; to = 1'b0; y = 0;
    forever begin
      @(posedge clk); #1; cyc++;
      if (out_valid) begin y = int'(out_sample); break; end
      if (cyc >= 200) begin to = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %0b, required 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %0b, required 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid); end
    n_cmp++; if (out_sample !== 16'sd0) begin n_bad++; $display("[TB] FAIL reset_out_sample: got %0d, required 0", out_sample); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_sat_flag: got %0b, required 0", sat_flag); end
  endtask

  task automatic test_identity();
    int y, cyc, e; bit to;
    do_reset();
    send(1000, '0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL ident_busy: got %0b, required 1", busy); end
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to) begin n_bad++; $display("[TB] FAIL ident_timeout: no out_valid, required one"); end
    n_cmp++; if (cyc !== LATENCY) begin n_bad++; $display("[TB] FAIL ident_latency: got %0d, required %0d", cyc, LATENCY); end
    n_cmp++; if (y !== e) begin n_bad++; $display("[TB] FAIL ident_value: got %0d, required %0d", y, e); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL ident_ready_at_out: got %0b, required 1", in_ready); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL ident_sat: got %0b, required 0", sat_flag); end
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ident_pulse: got %0b, required 0", out_valid); end
    n_cmp++; if (int'(out_sample) !== e) begin n_bad++; $display("[TB] FAIL ident_hold: got %0d, required %0d", out_sample, e); end
  endtask

  task automatic test_decay();
    int y, cyc, e; bit to;
    int xs[4] = '{16384, 0, 0, 0};
    do_reset();
    write_coef(0, 0, 8192);
    write_coef(0, 3, -8192);
    foreach (xs[i]) begin
      send(xs[i], '0);
      collect(y, cyc, to);
      e = exp_q.pop_front();
      n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL decay_%0d: got %0d (timeout=%0b), required %0d", i, y, to, e); end
    end
  endtask

  task automatic test_saturation();
    int y, cyc, e; bit to;
    do_reset();
    write_coef(0, 0, 32767);
    send(32767, '0);
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL sat_pos: got %0d, required %0d", y, e); end
    n_cmp++; if (sat_flag !== m_sat) begin n_bad++; $display("[TB] FAIL sat_flag_set: got %0b, required %0b", sat_flag, m_sat); end
    send(-32768, '0);
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL sat_neg: got %0d, required %0d", y, e); end
    sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    m_sat = 1'b0;
    n_cmp++; if (sat_flag !== 1'b0) begin n_bad++; $display("[TB] FAIL sat_clr: got %0b, required 0", sat_flag); end
    // Pulse sat_clr exactly on the stage-0 write-back edge, where it saturates.
    send(32767, '0);
    repeat (5) @(posedge clk);
    #1 sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    n_cmp++; if (sat_flag !== 1'b1) begin n_bad++; $display("[TB] FAIL sat_set_wins: got %0b, required 1", sat_flag); end
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL sat_pos2: got %0d, required %0d", y, e); end
  endtask

  task automatic test_busy_write();
    int y, cyc, e; bit to;
    do_reset();
    send(4000, '0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL bw_busy: got %0b, required 1", busy); end
    write_coef(1, 0, 8192);
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL bw_first: got %0d, required %0d", y, e); end
    send(4000, '0);
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL bw_second: got %0d, required %0d", y, e); end
  endtask

  task automatic test_bypass();
    int y, cyc, e; bit to;
    do_reset();
    write_coef(0, 0, 8192);
    write_coef(0, 3, -8192);
    write_coef(1, 0, -16384);
    write_coef(2, 1, 4096);
    send(-1234, 3'b111);
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (cyc !== LATENCY) begin n_bad++; $display("[TB] FAIL byp_latency: got %0d, required %0d", cyc, LATENCY); end
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL byp_value: got %0d, required %0d", y, e); end
    send(1000, 3'b000);
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL byp_history: got %0d, required %0d", y, e); end
  endtask

  task automatic test_coef_edges();
    int y, cyc, e; bit to;
    do_reset();
    write_coef(0, 5, 0);
    write_coef(0, 7, 0);
    write_coef(3, 0, 0);
    send(1000, '0);
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL bad_write_ignored: got %0d, required %0d", y, e); end
    // Coefficient write on the transfer edge applies to the following sample.
    in_sample = 16'sd1000; bypass = '0; in_valid = 1'b1;
    coef_stage = 2'd0; coef_idx = 3'd0; coef_wdata = 16'sd8192; coef_we = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; coef_we = 1'b0;
    model_run(1000, '0, e);
    exp_q.push_back(e);
    m_sh[0][0] = 8192;
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL same_edge_old: got %0d, required %0d", y, e); end
    send(1000, '0);
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL same_edge_new: got %0d, required %0d", y, e); end
  endtask

  task automatic test_abort();
    int y, cyc, e, seen; bit to;
    do_reset();
    send(1000, '0);
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL abort_pre: got %0d, required %0d", y, e); end
    write_coef(0, 0, 8192);
    send(1000, '0);
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_sample !== 16'sd0) begin n_bad++; $display("[TB] FAIL abort_outputs: out_valid=%0b out_sample=%0d, required 0/0", out_valid, out_sample); end
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_ready: in_ready=%0b busy=%0b, required 1/0", in_ready, busy); end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("[TB] FAIL abort_no_valid: got %0d pulses, required 0", seen); end
    send(500, '0);
    collect(y, cyc, to);
    e = exp_q.pop_front();
    n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL abort_identity: got %0d, required %0d", y, e); end
  endtask

  task automatic test_back_to_back();
    int y, cyc, e; bit to;
    do_reset();
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < 3; i++) write_coef(s, i, int'($urandom_range(0, 16384)) - 8192);
      for (int i = 3; i < 5; i++) write_coef(s, i, int'($urandom_range(0, 8192)) - 4096);
    end
    for (int n = 0; n < 6; n++) begin
      send(int'($urandom_range(0, 65535)) - 32768, NS'($urandom_range(0, 7)));
      collect(y, cyc, to);
      e = exp_q.pop_front();
      n_cmp++; if (cyc !== LATENCY) begin n_bad++; $display("[TB] FAIL b2b_latency_%0d: got %0d, required %0d", n, cyc, LATENCY); end
      n_cmp++; if (to || y !== e) begin n_bad++; $display("[TB] FAIL b2b_value_%0d: got %0d, required %0d", n, y, e); end
    end
    n_cmp++; if (sat_flag !== m_sat) begin n_bad++; $display("[TB] FAIL b2b_sat: got %0b, required %0b", sat_flag, m_sat); end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_sample = '0; coef_we = 1'b0; coef_stage = '0;
    coef_idx = '0; coef_wdata = '0; bypass = '0; sat_clr = 1'b0;
    #1;
    test_reset();
    test_identity();
    test_decay();
    test_saturation();
    test_busy_write();
    test_bypass();
    test_coef_edges();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
